sramlike_axi_bridge: RTL and testbench

//  Sits downstream of the inst and data sram-like bridges and converts their request streams to one AXI3 master port.

---
 rtl/sramlike_axi_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_sramlike_axi_bridge.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_axi_bridge.sv
// rtl/sramlike_axi_bridge.sv - inst/data sram-like request streams to one AXI3 master, single outstanding
//
// Purpose: arbitrates the inst (read-only) and data (read/write) sram-like ports onto a single AXI3
//   master port. One AXI transaction is in flight at a time. addr_ok is driven combinationally
//   in IDLE to the granted port. data_ok is a registered one-cycle pulse to the same port.
// Configuration: define SRAMLIKE_AXI_RR_EN for round-robin arbitration. Without it, data has fixed
//   priority over inst.
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   inst_req/size/addr -> inst_rdata/addr_ok/data_ok    inst sram-like port (reads only)
//   data_req/wr/size/addr/wdata -> data_rdata/addr_ok/data_ok   data sram-like port
//   ar*/r*/aw*/w*/b*                          AXI3 master channels (len 0, INCR, no lock/cache/prot)
module sramlike_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW_W = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  logic [2:0]  state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_owner;   // 1 = data port owns the transaction
  logic        aw_done;
  logic        w_done;
  logic        in_idle;
  logic        grant_data;
  logic        grant_inst;
  logic        aw_fin;
  logic        w_fin;

  // Responses carry nothing useful with a single outstanding transaction.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  assign in_idle = (state == S_IDLE) && !rst;

`ifdef SRAMLIKE_AXI_RR_EN
  logic last_data;  // 1 = data port won the most recent grant

  always_ff @(posedge clk) begin
    if (rst) begin
      last_data <= 1'b0;
    end else if (grant_data) begin
      last_data <= 1'b1;
    end else if (grant_inst) begin
      last_data <= 1'b0;
    end
  end

  assign grant_data = in_idle && data_req && (!inst_req || !last_data);
`else
  assign grant_data = in_idle && data_req;
`endif

  assign grant_inst   = in_idle && inst_req && !grant_data;
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // aw and w complete independently; *_fin means "done by the end of this cycle".
  assign aw_fin = aw_done || (awvalid && awready);
  assign w_fin  = w_done  || (wvalid && wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_size     <= 2'd0;
      lat_owner    <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_data) begin
            lat_owner <= 1'b1;
            lat_addr  <= data_addr;
            lat_size  <= data_size;
            lat_wdata <= data_wdata;
            state     <= data_wr ? S_AW_W : S_AR;
          end else if (grant_inst) begin
            lat_owner <= 1'b0;
            lat_addr  <= inst_addr;
            lat_size  <= inst_size;
            lat_wdata <= 32'd0;
            state     <= S_AR;
          end
        end
        S_AR: begin
          if (arready) state <= S_R;
        end
        S_R: begin
          if (rvalid) begin
            if (lat_owner) begin
              data_rdata   <= rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= rdata;
              inst_data_ok <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        S_AW_W: begin
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= S_B;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        S_B: begin
          if (bvalid) begin
            data_data_ok <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign arid    = lat_owner ? DATA_ID : INST_ID;
  assign araddr  = lat_addr;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, lat_size};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);

  assign awid    = DATA_ID;
  assign awaddr  = lat_addr;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, lat_size};
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state == S_AW_W) && !aw_done;

  assign wid     = DATA_ID;
  assign wdata   = lat_wdata;
  assign wlast   = 1'b1;
  assign wvalid  = (state == S_AW_W) && !w_done;
  assign bready  = (state == S_B);

  always_comb begin
    wstrb = 4'b1111;
    case (lat_size)
      2'b00:   wstrb = 4'b0001 << lat_addr[1:0];
      2'b01:   wstrb = 4'b0011 << lat_addr[1:0];
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// tb/tb_sramlike_axi_bridge.sv - self-checking bench for sramlike_axi_bridge
module tb_sramlike_axi_bridge;

`ifdef SRAMLIKE_AXI_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int ncmp;
  int nerr;
  logic       last_d;   // reference: data port won the latest grant
  logic [1:0] next_g;   // {data, inst} grant expected on the data_ok cycle of the last serve

  sramlike_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: returns {data_grant, inst_grant} and advances the last-grant memory.
  function automatic logic [1:0] model_grant(input logic ir, input logic dr);
    logic gd;
    gd = dr && (!ir || !RR || !last_d);
    if (gd) last_d = 1'b1;
    else if (ir) last_d = 1'b0;
    return {gd, ir && !gd};
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] off);
    int nbytes;
    if (size >= 2'd2) return 4'hF;
    nbytes = 1 << size;
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  // Present a request from the current negedge and check the grant.
  task automatic start(input logic owner, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [1:0] g;
    @(negedge clk);
    if (owner) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_size = size; inst_addr = addr;
    end
    #1;
    g = model_grant(inst_req, data_req);
    chk("grant", 32'({data_addr_ok, inst_addr_ok}), 32'(g));
  endtask

  // AXI slave for one granted transaction; returns at the data_ok cycle.
  task automatic serve(input logic owner, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                       input int d_ar, input int d_r, input int d_aw, input int d_w, input int d_b,
                       input logic [1:0] drop);
    int hs_ar, hs_aw, hs_w, both, done_k, exp_k;
    int n_ar, n_r, n_aw, n_w, n_b;
    logic [1:0] g;
    hs_ar = -1; hs_aw = -1; hs_w = -1; done_k = -1;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
    g = 2'b00;
    for (int k = 0; k < 200 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (drop[0]) inst_req = 1'b0;
        if (drop[1]) data_req = 1'b0;
      end
      both    = (hs_aw >= 0 && hs_w >= 0) ? ((hs_aw > hs_w) ? hs_aw : hs_w) : -1;
      arready = (k >= d_ar);
      rvalid  = (hs_ar >= 0 && n_r == 0 && k >= hs_ar + 1 + d_r);
      rdata   = rdat;
      awready = (k >= d_aw);
      wready  = (k >= d_w);
      bvalid  = (both >= 0 && n_b == 0 && k >= both + 1 + d_b);
      #1;
      if ((owner ? data_data_ok : inst_data_ok) === 1'b1) begin
        done_k = k;
        g = model_grant(inst_req, data_req);
        if (!wr) chk(owner ? "data_rdata" : "inst_rdata", owner ? data_rdata : inst_rdata, rdat);
        chk("next_grant", 32'({data_addr_ok, inst_addr_ok}), 32'(g));
      end else begin
        chk("busy_addr_ok", 32'({data_addr_ok, inst_addr_ok}), 32'd0);
      end
      chk("other_data_ok", 32'(owner ? inst_data_ok : data_data_ok), 32'd0);
      if (arvalid && arready) begin
        n_ar++; hs_ar = k;
        chk("araddr", araddr, addr);
        chk("arsize", 32'(arsize), 32'(size));
        chk("arid", 32'(arid), owner ? 32'd1 : 32'd0);
      end
      if (rvalid && rready) n_r++;
      if (awvalid && awready) begin
        n_aw++; hs_aw = k;
        chk("awaddr", awaddr, addr);
        chk("awsize", 32'(awsize), 32'(size));
        chk("awid", 32'(awid), 32'd1);
      end
      if (wvalid && wready) begin
        n_w++; hs_w = k;
        chk("wdata", wdata, wd);
        chk("wstrb", 32'(wstrb), 32'(exp_strb(size, addr[1:0])));
        chk("wlast_wid", 32'({wlast, wid}), 32'h11);
      end
      if (bvalid && bready) n_b++;
    end
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    next_g = g;
    exp_k = wr ? (((d_aw > d_w) ? d_aw : d_w) + d_b + 2) : (d_ar + d_r + 2);
    chk("latency", 32'(done_k), 32'(exp_k));
    chk("n_ar_r", 32'({n_ar, n_r}), wr ? 32'd0 : 32'({32'd1, 32'd1}));
    chk("n_aw_w_b", 32'(n_aw * 100 + n_w * 10 + n_b), wr ? 32'd111 : 32'd0);
  endtask

  task automatic txn(input logic owner, input logic wr, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                     input int d_ar, input int d_r, input int d_aw, input int d_w, input int d_b);
    start(owner, wr, size, addr, wd);
    serve(owner, wr, size, addr, wd, rdat, d_ar, d_r, d_aw, d_w, d_b, owner ? 2'b10 : 2'b01);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    #1;
    chk("addr_ok_in_rst", 32'({data_addr_ok, inst_addr_ok}), 32'd0);
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; last_d = 1'b0;
    #1;
    chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    chk("rst_oks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
  endtask

  initial begin
    logic [3:0]  seq;
    logic [1:0]  g;
    logic        own, wr;
    logic [1:0]  sz;
    logic [31:0] a;
    ncmp = 0; nerr = 0; last_d = 1'b0; next_g = 2'b00;
    rst = 1'b1;
    inst_req = 1'b0; inst_size = 2'd0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;

    do_reset();

    // Minimum-latency inst read.
    txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0, 32'h3C1A_0000, 0, 0, 0, 0, 0);
    // Half-word write at offset 2.
    txn(1'b1, 1'b1, 2'd1, 32'h1FC0_0012, 32'h0000_ABCD, 32'd0, 0, 0, 0, 0, 1);
    // w completes 3 cycles before aw, then aw before w, then both together.
    txn(1'b1, 1'b1, 2'd2, 32'h0000_1000, 32'h1234_5678, 32'd0, 0, 0, 3, 0, 0);
    txn(1'b1, 1'b1, 2'd0, 32'h0000_2003, 32'h0000_00EE, 32'd0, 0, 0, 0, 2, 2);
    txn(1'b1, 1'b1, 2'd0, 32'h0000_2001, 32'h0000_0011, 32'd0, 0, 0, 1, 1, 0);
    // Data read with ar and r back-pressure.
    txn(1'b1, 1'b0, 2'd0, 32'h0000_3002, 32'd0, 32'hDEAD_BEEF, 2, 3, 0, 0, 0);

    // Simultaneous requests: data first, inst granted in the data_ok cycle.
    do_reset();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_4000;
    data_wdata = 32'hCAFE_F00D;
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0100;
    #1;
    g = model_grant(1'b1, 1'b1);
    chk("tie_grant", 32'({data_addr_ok, inst_addr_ok}), 32'(g));
    chk("tie_data_first", 32'({data_addr_ok, inst_addr_ok}), 32'h2);
    serve(1'b1, 1'b1, 2'd2, 32'h0000_4000, 32'hCAFE_F00D, 32'd0, 0, 0, 1, 1, 1, 2'b10);
    chk("inst_after_data", 32'(next_g), 32'h1);
    serve(1'b0, 1'b0, 2'd2, 32'hBFC0_0100, 32'd0, 32'h0BAD_CAFE, 1, 0, 0, 0, 0, 2'b01);

    // Back-to-back contention: both ports keep requesting for four grants.
    do_reset();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_5000;
    data_wdata = 32'h5555_AAAA;
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC0_0200;
    #1;
    g = model_grant(1'b1, 1'b1);
    chk("cont_grant0", 32'({data_addr_ok, inst_addr_ok}), 32'(g));
    seq = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      own = g[1];
      seq[3 - i] = own;
      if (own)
        serve(1'b1, 1'b1, 2'd2, 32'h0000_5000, 32'h5555_AAAA, 32'd0, 0, 0, 0, 0, 0,
              (i == 3) ? 2'b11 : 2'b00);
      else
        serve(1'b0, 1'b0, 2'd2, 32'hBFC0_0200, 32'd0, 32'h7700_0000 + 32'(i), 0, 0, 0, 0, 0,
              (i == 3) ? 2'b11 : 2'b00);
      g = next_g;
    end
    chk("grant_sequence", 32'(seq), RR ? 32'hA : 32'hF);

    // Reset while in R: everything drops, no response, next request normal.
    start(1'b0, 1'b0, 2'd2, 32'hBFC0_0300, 32'd0);
    @(negedge clk);
    inst_req = 1'b0; arready = 1'b1;
    #1;
    chk("midrst_arvalid", 32'(arvalid), 32'd1);
    @(negedge clk);
    arready = 1'b0;
    #1;
    chk("midrst_in_r", 32'(rready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; last_d = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
    #1;
    chk("midrst_drop", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    end
    rvalid = 1'b0;
    txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0304, 32'd0, 32'h2468_ACE0, 1, 1, 0, 0, 0);

    // Randomized single-port traffic.
    for (int i = 0; i < 20; i++) begin
      own = 1'($urandom_range(0, 1));
      wr  = own ? 1'($urandom_range(0, 1)) : 1'b0;
      sz  = 2'($urandom_range(0, 2));
      a   = $urandom;
      a   = a & ~((32'd1 << sz) - 32'd1);
      txn(own, wr, sz, a, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
